// File: rtl/onfi_pkg.sv
// Shared types for the ONFI pin arbiter: FSM states, the control-pin bundle
// and its idle value, and a one-hot to index helper.
package onfi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    // Control pins of the ONFI interface; DQ is kept beside this bundle so
    // its width can follow the arbiter's DQ_W parameter.
    typedef struct packed {
        logic cen;
        logic cle;
        logic ale;
        logic wen;
        logic dqs_en;
        logic dq_en;
    } onfi_ctl_t;

    // Parked pins: chip deselected, write strobe high, all enables off.
    localparam onfi_ctl_t CTL_IDLE = '{cen: 1'b1, cle: 1'b0, ale: 1'b0,
                                       wen: 1'b1, dqs_en: 1'b0, dq_en: 1'b0};

    // Index of the highest set bit of a (one-hot) vector of up to 8 bits.
    function automatic int onehot_idx(input logic [7:0] v);
        int idx;
        idx = 0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/onfi_rr_picker.sv
// Combinational round-robin picker: first eligible request at or above ptr,
// wrapping around. Masked requesters are skipped.
module onfi_rr_picker #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     mask,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     win,
    output logic             valid
);

    logic [N-1:0] eligible;
    int           idx;

    assign eligible = req & ~mask;

    // Scan upward from ptr with wrap; the first eligible bit wins.
    always_comb begin
        win   = '0;
        valid = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N) idx = idx - N;
            if (!valid && eligible[idx]) begin
                win[idx] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/onfi_bus_arbiter.sv
// Round-robin owner of one ONFI pin interface shared by NREQ sequencers.
// A grant is held until the owner drops its request, followed by TURN_CYC
// idle cycles. Every pad output is a flop so the pins never glitch.
// Optional: define ONFI_ARB_TIMEOUT_EN to force a release after HOLD_MAX
// grant cycles and mask the offender until it drops its request.
//
// state | meaning
// IDLE  | no owner, pins parked, arbitrating on req_i
// GRANT | one owner, its pin values are registered onto the pads
// TURN  | pins parked for TURN_CYC cycles before the next arbitration
module onfi_bus_arbiter
    import onfi_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int DQ_W     = 8,
    parameter int TURN_CYC = 2,
    parameter int HOLD_MAX = 1024
) (
    input  logic                 onfi_clk,
    input  logic                 onfi_rst,
    input  logic [NREQ-1:0]      req_i,
    output logic [NREQ-1:0]      gnt_o,
    input  logic [NREQ-1:0]      req_cen_i,
    input  logic [NREQ-1:0]      req_cle_i,
    input  logic [NREQ-1:0]      req_ale_i,
    input  logic [NREQ-1:0]      req_wen_i,
    input  logic [NREQ-1:0]      req_dqs_en_i,
    input  logic [NREQ-1:0]      req_dq_en_i,
    input  logic [NREQ*DQ_W-1:0] req_dq_i,
    output logic                 onfi_cen,
    output logic                 onfi_cle,
    output logic                 onfi_ale,
    output logic                 onfi_wen,
    output logic                 onfi_dqs_en,
    output logic                 onfi_dq_en,
    output logic [DQ_W-1:0]      onfi_dq_o,
    output logic                 busy_o,
    output logic                 timeout_err_o
);

    localparam int         PTR_W     = (NREQ > 2) ? $clog2(NREQ) : 1;
    localparam logic [3:0] TURN_LOAD = (TURN_CYC > 0) ? 4'(TURN_CYC - 1) : 4'd0;

    typedef struct packed {
        onfi_ctl_t       ctl;
        logic [DQ_W-1:0] dq;
    } pins_t;

    localparam pins_t PINS_IDLE = '{ctl: CTL_IDLE, dq: '0};

    state_t           state, state_nxt;
    logic [NREQ-1:0]  gnt, gnt_nxt;
    logic [PTR_W-1:0] ptr, ptr_nxt;
    logic [PTR_W-1:0] owner, owner_nxt;
    logic [3:0]       turn_cnt, turn_cnt_nxt;
    pins_t            pins, pins_nxt, owner_pins;
    logic [NREQ-1:0]  pick_win, arb_mask;
    logic             pick_valid;
    int               win_idx;
    logic             forced;

    onfi_rr_picker #(.N(NREQ), .PTR_W(PTR_W)) u_picker (
        .req   (req_i),
        .mask  (arb_mask),
        .ptr   (ptr),
        .win   (pick_win),
        .valid (pick_valid)
    );

    assign win_idx = onehot_idx(8'(pick_win));

    assign owner_pins.ctl.cen    = req_cen_i[owner];
    assign owner_pins.ctl.cle    = req_cle_i[owner];
    assign owner_pins.ctl.ale    = req_ale_i[owner];
    assign owner_pins.ctl.wen    = req_wen_i[owner];
    assign owner_pins.ctl.dqs_en = req_dqs_en_i[owner];
    assign owner_pins.ctl.dq_en  = req_dq_en_i[owner];
    assign owner_pins.dq         = req_dq_i[int'(owner)*DQ_W +: DQ_W];

`ifdef ONFI_ARB_TIMEOUT_EN
    localparam int HOLD_W = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;

    logic [HOLD_W-1:0] hold_cnt;
    logic              tout_q;

    assign forced = (state == GRANT) && req_i[owner] &&
                    (hold_cnt == HOLD_W'(HOLD_MAX - 1));

    // Grant-length counter, offender mask and the one-cycle timeout pulse.
    always_ff @(posedge onfi_clk or posedge onfi_rst) begin
        if (onfi_rst) begin
            hold_cnt <= '0;
            arb_mask <= '0;
            tout_q   <= 1'b0;
        end else begin
            tout_q   <= forced;
            arb_mask <= (arb_mask & req_i) | (forced ? gnt : '0);
            if (state == GRANT) hold_cnt <= hold_cnt + 1'b1;
            else                hold_cnt <= '0;
        end
    end

    assign timeout_err_o = tout_q;
`else
    assign forced        = 1'b0;
    assign arb_mask      = '0;
    assign timeout_err_o = 1'b0;
`endif

    // State, grant, pointer, turnaround counter and pad flops.
    always_ff @(posedge onfi_clk or posedge onfi_rst) begin
        if (onfi_rst) begin
            state    <= IDLE;
            gnt      <= '0;
            ptr      <= '0;
            owner    <= '0;
            turn_cnt <= '0;
            pins     <= PINS_IDLE;
        end else begin
            state    <= state_nxt;
            gnt      <= gnt_nxt;
            ptr      <= ptr_nxt;
            owner    <= owner_nxt;
            turn_cnt <= turn_cnt_nxt;
            pins     <= pins_nxt;
        end
    end

    // Next-state logic; pins default to parked and only follow the owner
    // while it keeps its grant.
    always_comb begin
        state_nxt    = state;
        gnt_nxt      = gnt;
        ptr_nxt      = ptr;
        owner_nxt    = owner;
        turn_cnt_nxt = turn_cnt;
        pins_nxt     = PINS_IDLE;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    gnt_nxt   = pick_win;
                    owner_nxt = PTR_W'(win_idx);
                    ptr_nxt   = (win_idx == NREQ - 1) ? '0 : PTR_W'(win_idx + 1);
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (!req_i[owner] || forced) begin
                    gnt_nxt      = '0;
                    turn_cnt_nxt = TURN_LOAD;
                    state_nxt    = (TURN_CYC == 0) ? IDLE : TURN;
                end else begin
                    pins_nxt = owner_pins;
                end
            end
            TURN: begin
                if (turn_cnt == 4'd0) state_nxt = IDLE;
                else                  turn_cnt_nxt = turn_cnt - 4'd1;
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
            end
        endcase
    end

    assign gnt_o       = gnt;
    assign onfi_cen    = pins.ctl.cen;
    assign onfi_cle    = pins.ctl.cle;
    assign onfi_ale    = pins.ctl.ale;
    assign onfi_wen    = pins.ctl.wen;
    assign onfi_dqs_en = pins.ctl.dqs_en;
    assign onfi_dq_en  = pins.ctl.dq_en;
    assign onfi_dq_o   = pins.dq;
    assign busy_o      = (state != IDLE);

endmodule

// File: tb/tb_onfi_bus_arbiter.sv
// Directed bench for onfi_bus_arbiter: main instance with TURN_CYC=2 and a
// second instance with TURN_CYC=0, both with HOLD_MAX=16.
module tb_onfi_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0, req0 = '0;
    logic [3:0]  cen, cle, ale, wen, dqs, dqen;
    logic [31:0] dq;

    logic [3:0]  gnt, gnt_b;
    logic        pcen, pcle, pale, pwen, pdqs, pdqen, busy, tout;
    logic        bcen, bcle, bale, bwen, bdqs, bdqen, bbusy, btout;
    logic [7:0]  pdq, bdq;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [13:0] IDLE_P = {6'b100100, 8'h00};

    always #5 clk = ~clk;

    onfi_bus_arbiter #(.NREQ(4), .DQ_W(8), .TURN_CYC(2), .HOLD_MAX(16)) dut (
        .onfi_clk(clk), .onfi_rst(rst), .req_i(req), .gnt_o(gnt),
        .req_cen_i(cen), .req_cle_i(cle), .req_ale_i(ale), .req_wen_i(wen),
        .req_dqs_en_i(dqs), .req_dq_en_i(dqen), .req_dq_i(dq),
        .onfi_cen(pcen), .onfi_cle(pcle), .onfi_ale(pale), .onfi_wen(pwen),
        .onfi_dqs_en(pdqs), .onfi_dq_en(pdqen), .onfi_dq_o(pdq),
        .busy_o(busy), .timeout_err_o(tout)
    );

    onfi_bus_arbiter #(.NREQ(4), .DQ_W(8), .TURN_CYC(0), .HOLD_MAX(16)) dut0 (
        .onfi_clk(clk), .onfi_rst(rst), .req_i(req0), .gnt_o(gnt_b),
        .req_cen_i(cen), .req_cle_i(cle), .req_ale_i(ale), .req_wen_i(wen),
        .req_dqs_en_i(dqs), .req_dq_en_i(dqen), .req_dq_i(dq),
        .onfi_cen(bcen), .onfi_cle(bcle), .onfi_ale(bale), .onfi_wen(bwen),
        .onfi_dqs_en(bdqs), .onfi_dq_en(bdqen), .onfi_dq_o(bdq),
        .busy_o(bbusy), .timeout_err_o(btout)
    );

    function automatic logic [13:0] pins_a();
        return {pcen, pcle, pale, pwen, pdqs, pdqen, pdq};
    endfunction

    function automatic logic [13:0] pins_b();
        return {bcen, bcle, bale, bwen, bdqs, bdqen, bdq};
    endfunction

    // Background value every requester drives unless a test overrides it.
    function automatic logic [13:0] junk_p(input int k);
        return {6'b011011, 8'h30 + 8'(k)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_junk();
        for (int k = 0; k < 4; k++) begin
            cen[k] = 1'b0; cle[k] = 1'b1; ale[k] = 1'b1; wen[k] = 1'b0;
            dqs[k] = 1'b1; dqen[k] = 1'b1; dq[k*8 +: 8] = 8'h30 + 8'(k);
        end
    endtask

    task automatic set_req1(input logic [5:0] ctl, input logic [7:0] d);
        {cen[1], cle[1], ale[1], wen[1], dqs[1], dqen[1]} = ctl;
        dq[15:8] = d;
    endtask

    task automatic apply_reset();
        req = '0; req0 = '0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        set_junk();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++;
            if ({pins_a(), gnt, busy, tout} !== {IDLE_P, 4'b0, 1'b0, 1'b0}) begin
                n_bad++;
                $display("FAIL reset_idle cyc%0d: got pins=%h gnt=%b busy=%b tout=%b, want pins=%h gnt=0 busy=0 tout=0",
                         c, pins_a(), gnt, busy, tout, IDLE_P);
            end
        end
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_cmp++;
            if ({pins_a(), gnt, busy, pins_b(), gnt_b} !== {IDLE_P, 4'b0, 1'b0, IDLE_P, 4'b0}) begin
                n_bad++;
                $display("FAIL idle_no_req cyc%0d: got pins=%h gnt=%b busy=%b pins_b=%h gnt_b=%b, want idle",
                         c, pins_a(), gnt, busy, pins_b(), gnt_b);
            end
        end
    endtask

    task automatic test_passthrough();
        set_junk();
        req = 4'b0010;
        set_req1(6'b010101, 8'hEF);
        tick();
        n_cmp++;
        if ({gnt, busy, pins_a()} !== {4'b0010, 1'b1, IDLE_P}) begin
            n_bad++;
            $display("FAIL pass_grant: got gnt=%b busy=%b pins=%h, want gnt=0010 busy=1 pins=%h",
                     gnt, busy, pins_a(), IDLE_P);
        end
        tick();
        n_cmp++;
        if (pins_a() !== {6'b010101, 8'hEF}) begin
            n_bad++;
            $display("FAIL pass_pins_a: got %h want %h", pins_a(), {6'b010101, 8'hEF});
        end
        set_req1(6'b001101, 8'h01);
        dq[23:16] = 8'hEE;
        tick();
        n_cmp++;
        if (pins_a() !== {6'b001101, 8'h01}) begin
            n_bad++;
            $display("FAIL pass_pins_b: got %h want %h", pins_a(), {6'b001101, 8'h01});
        end
        req = 4'b0000;
        tick();
        n_cmp++;
        if ({gnt, busy, pins_a()} !== {4'b0000, 1'b1, IDLE_P}) begin
            n_bad++;
            $display("FAIL pass_release: got gnt=%b busy=%b pins=%h, want gnt=0000 busy=1 pins=%h",
                     gnt, busy, pins_a(), IDLE_P);
        end
        tick();
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL pass_turn2: got busy=%b want 1", busy);
        end
        tick();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL pass_back_idle: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_round_robin();
        int gap;
        int k;
        apply_reset();
        set_junk();
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            k = n % 4;
            gap = 0;
            while (gnt === 4'b0000 && gap < 20) begin
                n_cmp++;
                if (pins_a() !== IDLE_P) begin
                    n_bad++;
                    $display("FAIL rr_gap_pins n%0d: got %h want %h", n, pins_a(), IDLE_P);
                end
                gap++;
                tick();
            end
            n_cmp++;
            if (gap !== ((n == 0) ? 1 : 3)) begin
                n_bad++;
                $display("FAIL rr_gap n%0d: got %0d idle cycles want %0d", n, gap, (n == 0) ? 1 : 3);
            end
            n_cmp++;
            if (gnt !== 4'(1 << k)) begin
                n_bad++;
                $display("FAIL rr_order n%0d: got gnt=%b want %b", n, gnt, 4'(1 << k));
            end
            tick();
            n_cmp++;
            if (pins_a() !== junk_p(k)) begin
                n_bad++;
                $display("FAIL rr_pins n%0d: got %h want %h", n, pins_a(), junk_p(k));
            end
            repeat (3) tick();
            req[k] = 1'b0;
            tick();
            req[k] = 1'b1;
        end
        req = 4'b0000;
        repeat (5) tick();
        n_cmp++;
        if ({gnt, busy} !== {4'b0000, 1'b0}) begin
            n_bad++;
            $display("FAIL rr_drain: got gnt=%b busy=%b want 0000/0", gnt, busy);
        end
    endtask

    task automatic test_turnaround_zero();
        set_junk();
        req0 = 4'b0100;
        tick();
        n_cmp++;
        if (gnt_b !== 4'b0100) begin
            n_bad++;
            $display("FAIL turn0_grant2: got gnt=%b want 0100", gnt_b);
        end
        req0 = 4'b1100;
        repeat (2) tick();
        n_cmp++;
        if ({gnt_b, pins_b()} !== {4'b0100, junk_p(2)}) begin
            n_bad++;
            $display("FAIL turn0_no_preempt: got gnt=%b pins=%h want 0100 %h", gnt_b, pins_b(), junk_p(2));
        end
        req0 = 4'b1000;
        tick();
        n_cmp++;
        if ({gnt_b, pins_b()} !== {4'b0000, IDLE_P}) begin
            n_bad++;
            $display("FAIL turn0_release: got gnt=%b pins=%h want 0000 %h", gnt_b, pins_b(), IDLE_P);
        end
        tick();
        n_cmp++;
        if ({gnt_b, pins_b()} !== {4'b1000, IDLE_P}) begin
            n_bad++;
            $display("FAIL turn0_grant3: got gnt=%b pins=%h want 1000 %h", gnt_b, pins_b(), IDLE_P);
        end
        tick();
        n_cmp++;
        if (pins_b() !== junk_p(3)) begin
            n_bad++;
            $display("FAIL turn0_pins3: got %h want %h", pins_b(), junk_p(3));
        end
        req0 = 4'b0000;
        repeat (2) tick();
        n_cmp++;
        if (bbusy !== 1'b0) begin
            n_bad++;
            $display("FAIL turn0_drain: got busy=%b want 0", bbusy);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        set_junk();
        req = 4'b0010;
        set_req1(6'b000001, 8'h5A);
        repeat (2) tick();
        n_cmp++;
        if ({gnt, pins_a()} !== {4'b0010, 6'b000001, 8'h5A}) begin
            n_bad++;
            $display("FAIL rstmid_owner: got gnt=%b pins=%h want 0010 %h", gnt, pins_a(), {6'b000001, 8'h5A});
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({gnt, busy, pins_a()} !== {4'b0000, 1'b0, IDLE_P}) begin
            n_bad++;
            $display("FAIL rstmid_async: got gnt=%b busy=%b pins=%h want 0000 0 %h", gnt, busy, pins_a(), IDLE_P);
        end
        req = 4'b1001;
        tick();
        rst = 1'b0;
        tick();
        n_cmp++;
        if (gnt !== 4'b0001) begin
            n_bad++;
            $display("FAIL rstmid_first: got gnt=%b want 0001", gnt);
        end
        req = 4'b0000;
        repeat (4) tick();
    endtask

    task automatic test_timeout();
        int cnt;
        apply_reset();
        set_junk();
        req = 4'b0001;
`ifdef ONFI_ARB_TIMEOUT_EN
        req = 4'b0011;
        tick();
        cnt = 0;
        while (gnt === 4'b0001 && cnt < 40) begin
            n_cmp++;
            if (tout !== 1'b0) begin
                n_bad++;
                $display("FAIL tmo_early_pulse: got tout=%b at hold %0d want 0", tout, cnt);
            end
            cnt++;
            tick();
        end
        n_cmp++;
        if ({cnt, gnt, tout} !== {32'd16, 4'b0000, 1'b1}) begin
            n_bad++;
            $display("FAIL tmo_release: got hold=%0d gnt=%b tout=%b want 16 0000 1", cnt, gnt, tout);
        end
        tick();
        n_cmp++;
        if (tout !== 1'b0) begin
            n_bad++;
            $display("FAIL tmo_pulse_len: got tout=%b want 0", tout);
        end
        cnt = 0;
        while (gnt === 4'b0000 && cnt < 20) begin
            cnt++;
            tick();
        end
        n_cmp++;
        if (gnt !== 4'b0010) begin
            n_bad++;
            $display("FAIL tmo_next_owner: got gnt=%b want 0010", gnt);
        end
        repeat (3) tick();
        req[1] = 1'b0;
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (gnt !== 4'b0000) cnt++;
        end
        n_cmp++;
        if (cnt !== 0) begin
            n_bad++;
            $display("FAIL tmo_masked: got %0d granted cycles want 0", cnt);
        end
        req[0] = 1'b0;
        tick();
        req[0] = 1'b1;
        tick();
        n_cmp++;
        if (gnt !== 4'b0001) begin
            n_bad++;
            $display("FAIL tmo_unmask: got gnt=%b want 0001", gnt);
        end
`else
        tick();
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if ({gnt, tout} !== {4'b0001, 1'b0}) cnt++;
            tick();
        end
        n_cmp++;
        if (cnt !== 0) begin
            n_bad++;
            $display("FAIL hold_forever: got %0d cycles without grant or with tout, want 0", cnt);
        end
`endif
        req = 4'b0000;
        repeat (5) tick();
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_round_robin();
        test_turnaround_zero();
        test_reset_mid();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
